// File: rtl/abft_checksum_checker.sv
// abft_checksum_checker
//   Checks the fault-tolerance checksums of a 4-column accumulator array.
//   Each column's data sum (a) is compared with its checksum (b), and c is
//   compared with d. Each column is compared on the cycle its accumulators
//   hold their final value. The per-block result is reported as a column
//   error vector with a one-cycle done strobe. A sticky error flag, the first
//   failing column and a saturating error-block counter are kept for the host.
//
//   Optional feature macro: ABFT_TOL_EN
//     When defined, a pair mismatches when |x - y| > TOL.
//     When undefined, exact inequality is used and no subtractors are built.
//
// Ports:
//   clk                       clock
//   rst                       asynchronous active-high reset
//   clear_in                  column-0 final-value strobe (undelayed clear)
//   a/b/c/d_acc_0..3 [zBits]  accumulated values per column
//   err_clr                   synchronous clear of sticky status
//   done                      one-cycle pulse when a block's check completes
//   err_vec [arraySize]       per-column mismatch of the last completed block
//   err_flag                  sticky: any block reported an error
//   first_err_col [2]         lowest failing column of the block that set err_flag
//   err_count [cntBits]       number of erroring blocks, saturating
module abft_checksum_checker #(
    parameter int arraySize = 4,
    parameter int zBits     = 12,
    parameter int cntBits   = 8,
    parameter int TOL       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_in,
    input  logic [zBits-1:0]     a_acc_0,
    input  logic [zBits-1:0]     b_acc_0,
    input  logic [zBits-1:0]     c_acc_0,
    input  logic [zBits-1:0]     d_acc_0,
    input  logic [zBits-1:0]     a_acc_1,
    input  logic [zBits-1:0]     b_acc_1,
    input  logic [zBits-1:0]     c_acc_1,
    input  logic [zBits-1:0]     d_acc_1,
    input  logic [zBits-1:0]     a_acc_2,
    input  logic [zBits-1:0]     b_acc_2,
    input  logic [zBits-1:0]     c_acc_2,
    input  logic [zBits-1:0]     d_acc_2,
    input  logic [zBits-1:0]     a_acc_3,
    input  logic [zBits-1:0]     b_acc_3,
    input  logic [zBits-1:0]     c_acc_3,
    input  logic [zBits-1:0]     d_acc_3,
    input  logic                 err_clr,
    output logic                 done,
    output logic [arraySize-1:0] err_vec,
    output logic                 err_flag,
    output logic [1:0]           first_err_col,
    output logic [cntBits-1:0]   err_count
);

    // The port list is fixed at four columns.
    if (arraySize != 4 || TOL < 0) begin : g_param_check
        $error("abft_checksum_checker: arraySize must be 4 and TOL non-negative");
    end

`ifdef ABFT_TOL_EN
    localparam logic [zBits:0] TOL_Z = (zBits+1)'(TOL);
`endif

    function automatic logic pair_mm(input logic [zBits-1:0] x, input logic [zBits-1:0] y);
`ifdef ABFT_TOL_EN
        logic [zBits:0] diff;
        diff = (x >= y) ? ({1'b0, x} - {1'b0, y}) : ({1'b0, y} - {1'b0, x});
        return diff > TOL_Z;
`else
        return x != y;
`endif
    endfunction

    logic [zBits-1:0] a_acc [arraySize];
    logic [zBits-1:0] b_acc [arraySize];
    logic [zBits-1:0] c_acc [arraySize];
    logic [zBits-1:0] d_acc [arraySize];

    assign a_acc[0] = a_acc_0;
    assign b_acc[0] = b_acc_0;
    assign c_acc[0] = c_acc_0;
    assign d_acc[0] = d_acc_0;
    assign a_acc[1] = a_acc_1;
    assign b_acc[1] = b_acc_1;
    assign c_acc[1] = c_acc_1;
    assign d_acc[1] = d_acc_1;
    assign a_acc[2] = a_acc_2;
    assign b_acc[2] = b_acc_2;
    assign c_acc[2] = c_acc_2;
    assign d_acc[2] = d_acc_2;
    assign a_acc[3] = a_acc_3;
    assign b_acc[3] = b_acc_3;
    assign c_acc[3] = c_acc_3;
    assign d_acc[3] = d_acc_3;

    // sel[k] mirrors the accumulator stage's clear_k: clear_in delayed k+1 cycles.
    logic [arraySize-1:0] sel;
    logic [arraySize-1:0] mm;
    logic [arraySize-2:0] w;

    logic [arraySize-1:0] new_vec;
    logic                 flag_n;
    logic [1:0]           col_n;
    logic [cntBits-1:0]   cnt_n;
    logic                 found;

    always_comb begin
        mm = '0;
        for (int unsigned k = 0; k < arraySize; k++) begin
            mm[k] = pair_mm(a_acc[k], b_acc[k]) | pair_mm(c_acc[k], d_acc[k]);
        end
    end

    // err_clr is folded in before the completing block is applied, so a
    // collision leaves the status describing only the new block.
    always_comb begin
        new_vec = {mm[arraySize-1], w};
        flag_n  = err_clr ? 1'b0 : err_flag;
        col_n   = err_clr ? 2'b00 : first_err_col;
        cnt_n   = err_clr ? '0 : err_count;
        found   = 1'b0;
        if (sel[arraySize-1] && new_vec != '0) begin
            if (cnt_n != '1) begin
                cnt_n = cnt_n + cntBits'(1);
            end
            if (!flag_n) begin
                flag_n = 1'b1;
                for (int unsigned k = 0; k < arraySize; k++) begin
                    if (new_vec[k] && !found) begin
                        col_n = 2'(k);
                        found = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel           <= '0;
            w             <= '0;
            done          <= 1'b0;
            err_vec       <= '0;
            err_flag      <= 1'b0;
            first_err_col <= 2'b00;
            err_count     <= '0;
        end else begin
            sel  <= {sel[arraySize-2:0], clear_in};
            done <= sel[arraySize-1];
            for (int unsigned k = 0; k < arraySize - 1; k++) begin
                if (sel[k]) begin
                    w[k] <= mm[k];
                end
            end
            if (sel[arraySize-1]) begin
                err_vec <= new_vec;
            end
            err_flag      <= flag_n;
            first_err_col <= col_n;
            err_count     <= cnt_n;
        end
    end

endmodule

// File: tb/tb_abft_checksum_checker.sv
// Testbench for abft_checksum_checker: directed blocks with hand-computed
// expectations pushed into a scoreboard queue; a monitor pops one entry per
// done pulse. A second instance with cntBits = 2 shares all inputs.
module tb_abft_checksum_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_in;
    logic        err_clr;
    logic [11:0] a [4];
    logic [11:0] b [4];
    logic [11:0] c [4];
    logic [11:0] d [4];

    logic        done;
    logic [3:0]  err_vec;
    logic        err_flag;
    logic [1:0]  first_err_col;
    logic [7:0]  err_count;

    logic        sat_done;
    logic [3:0]  sat_vec;
    logic        sat_flag;
    logic [1:0]  sat_col;
    logic [1:0]  sat_cnt;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] vec;
        logic       flag;
        logic [1:0] col;
        logic [7:0] cnt;
        logic [1:0] sat;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    abft_checksum_checker #(.arraySize(4), .zBits(12), .cntBits(8), .TOL(1)) u_dut (
        .clk(clk), .rst(rst), .clear_in(clear_in),
        .a_acc_0(a[0]), .b_acc_0(b[0]), .c_acc_0(c[0]), .d_acc_0(d[0]),
        .a_acc_1(a[1]), .b_acc_1(b[1]), .c_acc_1(c[1]), .d_acc_1(d[1]),
        .a_acc_2(a[2]), .b_acc_2(b[2]), .c_acc_2(c[2]), .d_acc_2(d[2]),
        .a_acc_3(a[3]), .b_acc_3(b[3]), .c_acc_3(c[3]), .d_acc_3(d[3]),
        .err_clr(err_clr), .done(done), .err_vec(err_vec), .err_flag(err_flag),
        .first_err_col(first_err_col), .err_count(err_count)
    );

    abft_checksum_checker #(.arraySize(4), .zBits(12), .cntBits(2), .TOL(1)) u_sat (
        .clk(clk), .rst(rst), .clear_in(clear_in),
        .a_acc_0(a[0]), .b_acc_0(b[0]), .c_acc_0(c[0]), .d_acc_0(d[0]),
        .a_acc_1(a[1]), .b_acc_1(b[1]), .c_acc_1(c[1]), .d_acc_1(d[1]),
        .a_acc_2(a[2]), .b_acc_2(b[2]), .c_acc_2(c[2]), .d_acc_2(d[2]),
        .a_acc_3(a[3]), .b_acc_3(b[3]), .c_acc_3(c[3]), .d_acc_3(d[3]),
        .err_clr(err_clr), .done(sat_done), .err_vec(sat_vec), .err_flag(sat_flag),
        .first_err_col(sat_col), .err_count(sat_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] v, input logic f, input logic [1:0] col,
                            input logic [7:0] cnt, input logic [1:0] sat);
        exp_t e;
        e.vec  = v;
        e.flag = f;
        e.col  = col;
        e.cnt  = cnt;
        e.sat  = sat;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_clean();
        for (int k = 0; k < 4; k++) begin
            a[k] = 12'd100;
            b[k] = 12'd100;
            c[k] = 12'd7;
            d[k] = 12'd7;
        end
    endtask

    // Cycle i of the run: clear_in = clr[i], err_clr = eclr[i]; columns 0..2
    // corrupt b (101 vs 100), column 3 corrupts d (8 vs 7) when f_k[i] is set.
    task automatic run_seq(input logic [31:0] clr, input logic [31:0] f0, input logic [31:0] f1,
                           input logic [31:0] f2, input logic [31:0] f3,
                           input logic [31:0] eclr, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            clear_in = clr[i];
            err_clr  = eclr[i];
            b[0]     = f0[i] ? 12'd101 : 12'd100;
            b[1]     = f1[i] ? 12'd101 : 12'd100;
            b[2]     = f2[i] ? 12'd101 : 12'd100;
            d[3]     = f3[i] ? 12'd8 : 12'd7;
        end
        tick();
        clear_in = 1'b0;
        err_clr  = 1'b0;
        set_clean();
    endtask

    task automatic chk_status(input string tag, input logic [3:0] v, input logic f,
                              input logic [1:0] col, input logic [7:0] cnt, input logic [1:0] sat);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'(1'b0));
        chk({tag, "_vec"}, 32'(err_vec), 32'(v));
        chk({tag, "_flag"}, 32'(err_flag), 32'(f));
        chk({tag, "_col"}, 32'(first_err_col), 32'(col));
        chk({tag, "_cnt"}, 32'(err_count), 32'(cnt));
        chk({tag, "_satcnt"}, 32'(sat_cnt), 32'(sat));
    endtask

    // Monitor: one scoreboard entry per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 err_vec=%b, required no done (t=%0t)",
                             err_vec, $time);
                end else begin
                    e = sbq.pop_front();
                    chk("err_vec", 32'(err_vec), 32'(e.vec));
                    chk("err_flag", 32'(err_flag), 32'(e.flag));
                    chk("first_err_col", 32'(first_err_col), 32'(e.col));
                    chk("err_count", 32'(err_count), 32'(e.cnt));
                    chk("sat_done", 32'(sat_done), 32'(1'b1));
                    chk("sat_vec", 32'(sat_vec), 32'(e.vec));
                    chk("sat_count", 32'(sat_cnt), 32'(e.sat));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        clear_in = 1'b0;
        err_clr  = 1'b0;
        set_clean();
        repeat (3) tick();
        rst = 1'b0;
        chk_status("reset", 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0);

        // Clean block.
        push_exp(4'b0000, 1'b0, 2'd0, 8'd0, 2'd0);
        run_seq(32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6);

        // Single fault: column 2 corrupted only at T+3.
        push_exp(4'b0100, 1'b1, 2'd2, 8'd1, 2'd1);
        run_seq(32'h1, 32'h0, 32'h0, 32'h8, 32'h0, 32'h0, 6);

        // Skew: column 1 corrupted everywhere except T+2, then only at T+2.
        push_exp(4'b0000, 1'b1, 2'd2, 8'd1, 2'd1);
        run_seq(32'h1, 32'h0, 32'hFFFF_FFFB, 32'h0, 32'h0, 32'h0, 6);
        push_exp(4'b0010, 1'b1, 2'd2, 8'd2, 2'd2);
        run_seq(32'h1, 32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 6);

        // err_clr alone: status cleared, err_vec retained.
        run_seq(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 2);
        chk_status("errclr", 4'b0010, 1'b0, 2'd0, 8'd0, 2'd0);

        // Back-to-back: block 1 faults cols 0,3; block 2 (T+4) faults col 1.
        push_exp(4'b1001, 1'b1, 2'd0, 8'd1, 2'd1);
        push_exp(4'b0010, 1'b1, 2'd0, 8'd2, 2'd2);
        run_seq(32'h11, 32'h2, 32'h40, 32'h0, 32'h10, 32'h0, 10);

        // Three more column-0 faults bring err_count to 5.
        push_exp(4'b0001, 1'b1, 2'd0, 8'd3, 2'd3);
        push_exp(4'b0001, 1'b1, 2'd0, 8'd4, 2'd3);
        push_exp(4'b0001, 1'b1, 2'd0, 8'd5, 2'd3);
        run_seq(32'h111, 32'h222, 32'h0, 32'h0, 32'h0, 32'h0, 14);

        // Clear collision with an erroring completion on column 3.
        push_exp(4'b1000, 1'b1, 2'd3, 8'd1, 2'd1);
        run_seq(32'h1, 32'h0, 32'h0, 32'h0, 32'h10, 32'h10, 6);

        // Reset at T+2 of a faulty block: no done, everything zero.
        tick();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        b[0]     = 12'd101;
        tick();
        b[0] = 12'd100;
        #2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk_status("rst_mid", 4'b0000, 1'b0, 2'd0, 8'd0, 2'd0);

        // Six consecutive erroring blocks: narrow counter saturates at 3.
        for (int j = 0; j < 6; j++) begin
            push_exp(4'b0100, 1'b1, 2'd2, 8'(j + 1), (j < 2) ? 2'(j + 1) : 2'd3);
        end
        run_seq(32'h0011_1111, 32'h0, 32'h0, 32'h0088_8888, 32'h0, 32'h0, 26);
        chk_status("sat", 4'b0100, 1'b1, 2'd2, 8'd6, 2'd3);
        chk("sat_flag", 32'(sat_flag), 32'(1'b1));
        chk("sat_col", 32'(sat_col), 32'(2'd2));

        repeat (8) tick();
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
